// File: rtl/jpeg_input_arbiter.sv
// Two-source input arbiter for the JPEG decoder: one source owns the decoder for a whole image.
// Define JPEG_ARB_STATS_EN to add the per-source completed-image counters img_cnt0_o/img_cnt1_o.
module jpeg_input_arbiter #(
    parameter int STRB_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s0_valid_i,
    input  logic [31:0]       s0_data_i,
    input  logic [STRB_W-1:0] s0_strb_i,
    input  logic              s0_last_i,
    output logic              s0_accept_o,
    input  logic              s1_valid_i,
    input  logic [31:0]       s1_data_i,
    input  logic [STRB_W-1:0] s1_strb_i,
    input  logic              s1_last_i,
    output logic              s1_accept_o,
    output logic              core_valid_o,
    output logic [31:0]       core_data_o,
    output logic [STRB_W-1:0] core_strb_o,
    output logic              core_last_o,
    input  logic              core_accept_i,
    input  logic              core_idle_i,
    output logic              owner_o,
    output logic              owner_valid_o
`ifdef JPEG_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  img_cnt0_o,
    output logic [CNT_W-1:0]  img_cnt1_o
`endif
);

    // state  | meaning
    // IDLE   | no owner; waits for decoder idle and a source request
    // STREAM | owner's beats pass straight through to the decoder
    // DRAIN  | last beat sent; waits for decoder idle before re-arbitrating
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_q, rr_d;

    logic              sel_valid;
    logic              sel_last;
    logic [31:0]       sel_data;
    logic [STRB_W-1:0] sel_strb;
    logic              grant_src;

    assign sel_valid = owner_q ? s1_valid_i : s0_valid_i;
    assign sel_last  = owner_q ? s1_last_i  : s0_last_i;
    assign sel_data  = owner_q ? s1_data_i  : s0_data_i;
    assign sel_strb  = owner_q ? s1_strb_i  : s0_strb_i;

    // A tie goes to the round-robin pointer; a lone request wins outright.
    assign grant_src = (s0_valid_i && s1_valid_i) ? rr_q : s1_valid_i;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        core_valid_o  = 1'b0;
        core_data_o   = '0;
        core_strb_o   = '0;
        core_last_o   = 1'b0;
        s0_accept_o   = 1'b0;
        s1_accept_o   = 1'b0;
        owner_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_idle_i && (s0_valid_i || s1_valid_i)) begin
                    state_d = ST_STREAM;
                    owner_d = grant_src;
                    rr_d    = ~grant_src;
                end
            end
            ST_STREAM: begin
                owner_valid_o = 1'b1;
                core_valid_o  = sel_valid;
                core_data_o   = sel_data;
                core_strb_o   = sel_strb;
                core_last_o   = sel_last;
                s0_accept_o   = ~owner_q & core_accept_i;
                s1_accept_o   = owner_q & core_accept_i;
                if (sel_valid && core_accept_i && sel_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                owner_valid_o = 1'b1;
                if (core_idle_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign owner_o = owner_q;

`ifdef JPEG_ARB_STATS_EN
    logic             last_xfer;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    assign last_xfer = (state_q == ST_STREAM) && sel_valid && core_accept_i && sel_last;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (last_xfer && !owner_q && !(&cnt0_q)) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (last_xfer && owner_q && !(&cnt1_q)) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign img_cnt0_o = cnt0_q;
    assign img_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_jpeg_input_arbiter.sv
// Directed bench for jpeg_input_arbiter; counter checks are compiled in with JPEG_ARB_STATS_EN.
module tb_jpeg_input_arbiter;

    localparam int STRB_W = 4;
    localparam int CNT_W  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              s0_valid_i = 1'b0, s1_valid_i = 1'b0;
    logic [31:0]       s0_data_i = '0, s1_data_i = '0;
    logic [STRB_W-1:0] s0_strb_i = '0, s1_strb_i = '0;
    logic              s0_last_i = 1'b0, s1_last_i = 1'b0;
    logic              s0_accept_o, s1_accept_o;
    logic              core_valid_o, core_last_o;
    logic [31:0]       core_data_o;
    logic [STRB_W-1:0] core_strb_o;
    logic              core_accept_i = 1'b1;
    logic              core_idle_i = 1'b1;
    logic              owner_o, owner_valid_o;
`ifdef JPEG_ARB_STATS_EN
    logic [CNT_W-1:0]  img_cnt0_o, img_cnt1_o;
`endif

    // {core_valid, core_last, s0_accept, s1_accept, owner_valid, owner}
    logic [5:0] flags;
    assign flags = {core_valid_o, core_last_o, s0_accept_o, s1_accept_o, owner_valid_o, owner_o};

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    jpeg_input_arbiter #(.STRB_W(STRB_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s0_valid_i    (s0_valid_i),
        .s0_data_i     (s0_data_i),
        .s0_strb_i     (s0_strb_i),
        .s0_last_i     (s0_last_i),
        .s0_accept_o   (s0_accept_o),
        .s1_valid_i    (s1_valid_i),
        .s1_data_i     (s1_data_i),
        .s1_strb_i     (s1_strb_i),
        .s1_last_i     (s1_last_i),
        .s1_accept_o   (s1_accept_o),
        .core_valid_o  (core_valid_o),
        .core_data_o   (core_data_o),
        .core_strb_o   (core_strb_o),
        .core_last_o   (core_last_o),
        .core_accept_i (core_accept_i),
        .core_idle_i   (core_idle_i),
        .owner_o       (owner_o),
        .owner_valid_o (owner_valid_o)
`ifdef JPEG_ARB_STATS_EN
        ,
        .img_cnt0_o    (img_cnt0_o),
        .img_cnt1_o    (img_cnt1_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_sources();
        s0_valid_i = 1'b0; s0_data_i = '0; s0_strb_i = '0; s0_last_i = 1'b0;
        s1_valid_i = 1'b0; s1_data_i = '0; s1_strb_i = '0; s1_last_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        clear_sources();
        core_accept_i = 1'b1;
        core_idle_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        rst_i = 1'b0;
        s0_valid_i = 1'b1; s0_data_i = 32'hDEAD_BEEF; s0_last_i = 1'b1;
        #1;
        n_total++;
        if (flags !== 6'b000000) $display("FAIL reset_flags got %b want 000000", flags);
        else n_pass++;
        clear_sources();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000000) $display("FAIL idle_flags got %b want 000000", flags);
        else n_pass++;
        n_total++;
        if ({core_data_o, core_strb_o} !== 36'h0) $display("FAIL idle_data got %h want 0", {core_data_o, core_strb_o});
        else n_pass++;
`ifdef JPEG_ARB_STATS_EN
        n_total++;
        if ({img_cnt0_o, img_cnt1_o} !== 4'h0) $display("FAIL reset_cnt got %h want 0", {img_cnt0_o, img_cnt1_o});
        else n_pass++;
`endif
    endtask

    task automatic test_single_source();
        apply_reset();
        s0_valid_i = 1'b1; s0_data_i = 32'hA000_0000; s0_strb_i = 4'h1; s0_last_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000000) $display("FAIL c1_request_cycle got %b want 000000", flags);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            s0_data_i = 32'hA000_0000 + 32'(i);
            s0_strb_i = 4'(1 << i);
            s0_last_i = (i == 3);
            @(negedge clk_i);
            n_total++;
            if (flags !== {1'b1, (i == 3), 4'b1010}) $display("FAIL c1_beat%0d_flags got %b want %b", i, flags, {1'b1, (i == 3), 4'b1010});
            else n_pass++;
            n_total++;
            if (core_data_o !== 32'hA000_0000 + 32'(i) || core_strb_o !== 4'(1 << i))
                $display("FAIL c1_beat%0d_data got %h/%h want %h/%h", i, core_data_o, core_strb_o, 32'hA000_0000 + 32'(i), 4'(1 << i));
            else n_pass++;
            tick();
        end
        s0_valid_i = 1'b1; s0_last_i = 1'b0; s0_data_i = 32'hA000_0010;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000010) $display("FAIL c1_drain got %b want 000010", flags);
        else n_pass++;
        s0_valid_i = 1'b0;
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000000) $display("FAIL c1_back_to_idle got %b want 000000", flags);
        else n_pass++;
    endtask

    task automatic test_tie();
        apply_reset();
        s0_valid_i = 1'b1; s0_data_i = 32'h100; s0_last_i = 1'b0;
        s1_valid_i = 1'b1; s1_data_i = 32'h200; s1_last_i = 1'b1;
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b101010 || core_data_o !== 32'h100) $display("FAIL c2_first_grant got %b/%h want 101010/100", flags, core_data_o);
        else n_pass++;
        tick();
        s0_data_i = 32'h101; s0_last_i = 1'b1;
        tick();
        s0_valid_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000010) $display("FAIL c2_drain_holds_s1 got %b want 000010", flags);
        else n_pass++;
        tick();
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b110111 || core_data_o !== 32'h200) $display("FAIL c2_second_grant got %b/%h want 110111/200", flags, core_data_o);
        else n_pass++;
        tick();
        s0_valid_i = 1'b1; s0_data_i = 32'h102; s0_last_i = 1'b1;
        s1_data_i = 32'h201;
        tick();
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b111010 || core_data_o !== 32'h102) $display("FAIL c2_third_grant got %b/%h want 111010/102", flags, core_data_o);
        else n_pass++;
        tick();
        clear_sources();
        tick();
    endtask

    task automatic test_accept_toggle();
        int b;
        logic acc;
        apply_reset();
        s1_valid_i = 1'b1; s1_data_i = 32'h300; s1_last_i = 1'b0;
        tick();
        s0_valid_i = 1'b1; s0_data_i = 32'h0BAD; s0_last_i = 1'b1;
        b = 0;
        for (int c = 0; c < 5; c++) begin
            acc = (c % 2 == 0);
            core_accept_i = acc;
            s1_data_i = 32'h300 + 32'(b);
            s1_last_i = (b == 2);
            @(negedge clk_i);
            n_total++;
            if (flags !== {1'b1, (b == 2), 1'b0, acc, 2'b11} || core_data_o !== 32'h300 + 32'(b))
                $display("FAIL c3_cycle%0d got %b/%h want %b/%h", c, flags, core_data_o, {1'b1, (b == 2), 1'b0, acc, 2'b11}, 32'h300 + 32'(b));
            else n_pass++;
            tick();
            if (acc) b++;
        end
        s1_valid_i = 1'b0;
        core_accept_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000011) $display("FAIL c3_drain got %b want 000011", flags);
        else n_pass++;
        clear_sources();
        tick();
    endtask

    task automatic test_drain_hold();
        apply_reset();
        s0_valid_i = 1'b1; s0_data_i = 32'h400; s0_last_i = 1'b1;
        tick();
        tick();
        core_idle_i = 1'b0;
        s0_data_i = 32'h401;
        s1_valid_i = 1'b1; s1_data_i = 32'h500; s1_last_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            n_total++;
            if (flags !== 6'b000010) $display("FAIL c4_drain_cycle%0d got %b want 000010", c, flags);
            else n_pass++;
            tick();
        end
        core_idle_i = 1'b1;
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000000) $display("FAIL c4_idle_after_drain got %b want 000000", flags);
        else n_pass++;
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b110111 || core_data_o !== 32'h500) $display("FAIL c4_next_grant got %b/%h want 110111/500", flags, core_data_o);
        else n_pass++;
        tick();
        clear_sources();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        s0_valid_i = 1'b1; s0_data_i = 32'h600; s0_last_i = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            s0_data_i = 32'h600 + 32'(b);
            tick();
        end
        s0_data_i = 32'h602;
        #2;
        rst_i = 1'b0;
        #1;
        n_total++;
        if (flags !== 6'b000000 || core_data_o !== 32'h0) $display("FAIL c5_async_reset got %b/%h want 000000/0", flags, core_data_o);
        else n_pass++;
        @(posedge clk_i);
        @(negedge clk_i);
        s0_valid_i = 1'b0;
        s1_valid_i = 1'b1; s1_data_i = 32'h700; s1_last_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_total++;
        if (flags !== 6'b000000) $display("FAIL c5_release_idle got %b want 000000", flags);
        else n_pass++;
        tick();
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b100111 || core_data_o !== 32'h700) $display("FAIL c5_s1_beat0 got %b/%h want 100111/700", flags, core_data_o);
        else n_pass++;
        tick();
        s1_data_i = 32'h701; s1_last_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b110111 || core_data_o !== 32'h701) $display("FAIL c5_s1_beat1 got %b/%h want 110111/701", flags, core_data_o);
        else n_pass++;
        tick();
        s1_valid_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (flags !== 6'b000011) $display("FAIL c5_drain got %b want 000011", flags);
        else n_pass++;
        clear_sources();
        tick();
    endtask

`ifdef JPEG_ARB_STATS_EN
    task automatic run_image(input logic src, input int nbeats);
        int  b = 0;
        bit  done = 0;
        logic acc;
        for (int c = 0; c < 40 && !done; c++) begin
            if (src) begin
                s1_valid_i = 1'b1; s1_data_i = 32'h1_0000 + 32'(b); s1_last_i = (b == nbeats - 1);
            end else begin
                s0_valid_i = 1'b1; s0_data_i = 32'h0_1000 + 32'(b); s0_last_i = (b == nbeats - 1);
            end
            @(negedge clk_i);
            acc = src ? s1_accept_o : s0_accept_o;
            tick();
            if (acc) begin
                b++;
                if (b == nbeats) done = 1;
            end
        end
        clear_sources();
        repeat (2) tick();
        if (!done) begin
            n_total++;
            $display("FAIL run_image_timeout src %0d beats sent %0d want %0d", src, b, nbeats);
        end
    endtask

    task automatic test_stats();
        apply_reset();
        run_image(1'b0, 2);
        run_image(1'b0, 1);
        run_image(1'b0, 3);
        run_image(1'b1, 1);
        n_total++;
        if (img_cnt0_o !== 2'd3 || img_cnt1_o !== 2'd1) $display("FAIL c6_counts got %0d/%0d want 3/1", img_cnt0_o, img_cnt1_o);
        else n_pass++;
        run_image(1'b0, 1);
        run_image(1'b0, 2);
        n_total++;
        if (img_cnt0_o !== 2'd3 || img_cnt1_o !== 2'd1) $display("FAIL c6_saturate got %0d/%0d want 3/1", img_cnt0_o, img_cnt1_o);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_source();
        test_tie();
        test_accept_toggle();
        test_drain_hold();
        test_async_reset();
`ifdef JPEG_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
